// File: rtl/regfile_stream_ctrl_if.sv
// Register-file bulk access bundle: control, register-file ports and both streams.
// slave = controller side, master = initiator / environment side.
interface regfile_stream_ctrl_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5
) ();
    logic              i_start;
    logic              i_mode;
    logic              i_abort;
    logic              o_busy;
    logic              o_done;
    logic [ADDR_W-1:0] o_RA;
    logic [DATA_W-1:0] i_BUS_A;
    logic [ADDR_W-1:0] o_RW;
    logic [DATA_W-1:0] o_BUS_W;
    logic              o_WE;
    logic [DATA_W-1:0] o_tdata;
    logic              o_tvalid;
    logic              i_tready;
    logic [DATA_W-1:0] i_tdata;
    logic              i_tvalid;
    logic              o_tready;

    modport slave (
        input  i_start, i_mode, i_abort, i_BUS_A,
        input  i_tready, i_tdata, i_tvalid,
        output o_busy, o_done, o_RA, o_RW, o_BUS_W, o_WE,
        output o_tdata, o_tvalid, o_tready
    );

    modport master (
        output i_start, i_mode, i_abort, i_BUS_A,
        output i_tready, i_tdata, i_tvalid,
        input  o_busy, o_done, o_RA, o_RW, o_BUS_W, o_WE,
        input  o_tdata, o_tvalid, o_tready
    );
endinterface

// File: rtl/regfile_stream_ctrl.sv
// Bulk DUMP (regfile -> stream) / LOAD (stream -> regfile) initiator.
// Ports: i_clk, i_rst (sync, active high), bus (slave modport of the bundle).
module regfile_stream_ctrl #(
    parameter int DATA_W    = 32,
    parameter int ADDR_W    = 5,
    parameter int NUM_REGS  = 32,
    parameter int FIRST_REG = 0
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    regfile_stream_ctrl_if.slave  bus
);
    typedef enum logic [2:0] {
        S_IDLE,
        S_RD_ISSUE,
        S_RD_CAPTURE,
        S_SEND,
        S_LOAD,
        S_DONE
    } state_t;

    localparam logic [ADDR_W-1:0] IDX_FIRST = ADDR_W'(FIRST_REG);
    localparam logic [ADDR_W-1:0] IDX_LAST  = ADDR_W'(NUM_REGS - 1);

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] idx_q, idx_d;
    logic [DATA_W-1:0] tdata_q, tdata_d;
    logic              tvalid_q, tvalid_d;
    logic              kill;

    // Reset and abort both suppress any side effect in the current cycle.
    assign kill = i_rst | bus.i_abort;

    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        tdata_d  = tdata_q;
        tvalid_d = tvalid_q;
        unique case (state_q)
            S_IDLE: begin
                if (bus.i_start) begin
                    idx_d   = IDX_FIRST;
                    state_d = bus.i_mode ? S_LOAD : S_RD_ISSUE;
                end
            end
            S_RD_ISSUE: begin
                state_d = S_RD_CAPTURE;
            end
            S_RD_CAPTURE: begin
                tdata_d  = bus.i_BUS_A;
                tvalid_d = 1'b1;
                state_d  = S_SEND;
            end
            S_SEND: begin
                if (bus.i_tready) begin
                    tvalid_d = 1'b0;
                    if (idx_q == IDX_LAST) begin
                        state_d = S_DONE;
                    end else begin
                        idx_d   = idx_q + 1'b1;
                        state_d = S_RD_ISSUE;
                    end
                end
            end
            S_LOAD: begin
                if (bus.i_tvalid) begin
                    if (idx_q == IDX_LAST) begin
                        state_d = S_DONE;
                    end else begin
                        idx_d = idx_q + 1'b1;
                    end
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
        if (bus.i_abort) begin
            state_d  = S_IDLE;
            tvalid_d = 1'b0;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q  <= S_IDLE;
            idx_q    <= '0;
            tdata_q  <= '0;
            tvalid_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            tdata_q  <= tdata_d;
            tvalid_q <= tvalid_d;
        end
    end

    assign bus.o_busy   = (state_q != S_IDLE) && (state_q != S_DONE);
    assign bus.o_done   = (state_q == S_DONE);
    assign bus.o_RA     = idx_q;
    assign bus.o_RW     = idx_q;
    assign bus.o_BUS_W  = bus.i_tdata;
    assign bus.o_tdata  = tdata_q;
    assign bus.o_tvalid = tvalid_q;
    // tready is gated too so a killed cycle is never seen as an accepted word.
    assign bus.o_tready = (state_q == S_LOAD) && !kill;
    assign bus.o_WE     = (state_q == S_LOAD) && bus.i_tvalid && !kill;
endmodule

// File: tb/tb_regfile_stream_ctrl.sv
// Scoreboard bench for regfile_stream_ctrl with a behavioural 32x32 register file.
// dut0 uses FIRST_REG=0, dut1 uses FIRST_REG=1.
module tb_regfile_stream_ctrl;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    regfile_stream_ctrl_if #(.DATA_W(32), .ADDR_W(5)) b0 ();
    regfile_stream_ctrl_if #(.DATA_W(32), .ADDR_W(5)) b1 ();

    regfile_stream_ctrl #(.FIRST_REG(0)) dut0 (
        .i_clk(clk), .i_rst(rst), .bus(b0)
    );
    regfile_stream_ctrl #(.FIRST_REG(1)) dut1 (
        .i_clk(clk), .i_rst(rst), .bus(b1)
    );

    logic [31:0] mem0 [32];
    logic [31:0] mem1 [32];
    logic [4:0]  ra0_q, ra1_q;

    always @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k < 32; k++) begin
                mem0[k] <= 32'hA500_0000 + k;
                mem1[k] <= 32'hA500_0000 + k;
            end
        end else begin
            if (b0.o_WE) mem0[b0.o_RW] <= b0.o_BUS_W;
            if (b1.o_WE) mem1[b1.o_RW] <= b1.o_BUS_W;
        end
        ra0_q <= b0.o_RA;
        ra1_q <= b1.o_RA;
    end
    assign b0.i_BUS_A = mem0[ra0_q];
    assign b1.i_BUS_A = mem1[ra1_q];

    logic [31:0] q0 [$];
    logic [31:0] q1 [$];
    logic [36:0] wq [$];

    int  done0 = 0, done1 = 0;
    int  last_hs0 = 0, prev_hs0 = 0;
    bit  have_prev = 0, spacing_on = 0, done_chk = 0;
    bit  hold_v0 = 0;
    logic [31:0] hold_d0;
    int  we_bad = 0, ra_zero = 0, beats1 = 0;

    task automatic check(input string name, input logic [63:0] got,
                         input logic [63:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    initial begin
        forever begin
            @(negedge clk);
            if (!rst) begin
                if (hold_v0) begin
                    check("tvalid_held", b0.o_tvalid, 1);
                    check("tdata_stable", b0.o_tdata, hold_d0);
                end
                if (b0.o_tvalid && b0.i_tready) begin
                    if (q0.size() == 0) check("dump_extra", 1, 0);
                    else check("dump_word", b0.o_tdata, q0.pop_front());
                    if (spacing_on && have_prev)
                        check("beat_spacing", cyc - prev_hs0, 3);
                    prev_hs0 = cyc;
                    have_prev = 1;
                    last_hs0 = cyc;
                end
                hold_v0 = b0.o_tvalid && !b0.i_tready;
                hold_d0 = b0.o_tdata;
                if (b0.o_WE) begin
                    if (!b0.i_tvalid) we_bad++;
                    if (wq.size() == 0) check("we_extra", 1, 0);
                    else check("write", {b0.o_RW, b0.o_BUS_W}, wq.pop_front());
                end
                if (b0.o_done) begin
                    done0++;
                    if (done_chk) check("done_latency", cyc - last_hs0, 1);
                end
            end
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            if (!rst) begin
                if (b1.o_busy && b1.o_RA == 5'd0) ra_zero++;
                if (b1.o_tvalid && b1.i_tready) begin
                    beats1++;
                    if (q1.size() == 0) check("dump1_extra", 1, 0);
                    else check("dump1_word", b1.o_tdata, q1.pop_front());
                end
                if (b1.o_done) done1++;
            end
        end
    end

    task automatic start0(input bit mode);
        b0.i_mode  = mode;
        b0.i_start = 1'b1;
        @(posedge clk);
        #1 b0.i_start = 1'b0;
    endtask

    task automatic wait_done(input bit sel, input bit tog, input int lim);
        int base;
        int t;
        base = sel ? done1 : done0;
        t = 0;
        while ((sel ? done1 : done0) == base && t < lim) begin
            @(posedge clk);
            #1;
            if (tog) b0.i_tready = ~b0.i_tready;
            t++;
        end
        if ((sel ? done1 : done0) == base) check("done_timeout", 1, 0);
        b0.i_tready = 1'b1;
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int base;
        int c;
        int k;
        rst = 1'b1;
        b0.i_start = 1'b1; b0.i_mode = 1'b0; b0.i_abort = 1'b0;
        b0.i_tready = 1'b1; b0.i_tdata = 32'h1234; b0.i_tvalid = 1'b1;
        b1.i_start = 1'b1; b1.i_mode = 1'b0; b1.i_abort = 1'b0;
        b1.i_tready = 1'b1; b1.i_tdata = '0; b1.i_tvalid = 1'b0;

        // 1: reset with start held
        @(posedge clk);
        @(negedge clk);
        check("rst_busy", b0.o_busy, 0);
        check("rst_done", b0.o_done, 0);
        check("rst_tvalid", b0.o_tvalid, 0);
        check("rst_tdata", b0.o_tdata, 0);
        check("rst_tready", b0.o_tready, 0);
        check("rst_we", b0.o_WE, 0);
        check("rst_ra", b0.o_RA, 0);
        check("rst_rw", b0.o_RW, 0);
        check("bus_w_mirror", b0.o_BUS_W, 32'h1234);
        @(posedge clk);
        @(negedge clk);
        check("rst2_busy", b0.o_busy, 0);
        check("rst2_we", b0.o_WE, 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        b0.i_start = 1'b0; b0.i_tvalid = 1'b0;
        b1.i_start = 1'b0;
        @(negedge clk);
        check("post_rst_busy", b0.o_busy, 0);

        // 2: full-rate dump
        for (int j = 0; j < 32; j++) q0.push_back(32'hA500_0000 + j);
        have_prev = 0; spacing_on = 1; done_chk = 1;
        @(posedge clk);
        #1;
        start0(1'b0);
        check("busy_dump", b0.o_busy, 1);
        wait_done(1'b0, 1'b0, 400);
        check("dump2_count", q0.size(), 0);
        check("idle_busy", b0.o_busy, 0);
        spacing_on = 0;

        // 3: dump with ready toggling
        for (int j = 0; j < 32; j++) q0.push_back(32'hA500_0000 + j);
        start0(1'b0);
        wait_done(1'b0, 1'b1, 800);
        check("dump3_count", q0.size(), 0);

        // 4: gapped load then readback
        done_chk = 0;
        start0(1'b1);
        k = 0; c = 0;
        while (k < 32) begin
            if (c % 3 == 2) begin
                b0.i_tvalid = 1'b0;
            end else begin
                b0.i_tvalid = 1'b1;
                b0.i_tdata  = 32'h1000 + k;
                wq.push_back({5'(k), 32'h1000 + k});
                k++;
            end
            c++;
            @(posedge clk);
            #1;
        end
        b0.i_tvalid = 1'b0;
        wait_done(1'b0, 1'b0, 20);
        check("load4_count", wq.size(), 0);
        check("we_only_valid", we_bad, 0);
        done_chk = 1;
        for (int j = 0; j < 32; j++) q0.push_back(32'h1000 + j);
        start0(1'b0);
        wait_done(1'b0, 1'b0, 400);
        check("readback_count", q0.size(), 0);

        // 5: FIRST_REG=1 dump
        for (int j = 1; j < 32; j++) q1.push_back(32'hA500_0000 + j);
        b1.i_mode = 1'b0;
        b1.i_start = 1'b1;
        @(posedge clk);
        #1 b1.i_start = 1'b0;
        wait_done(1'b1, 1'b0, 400);
        check("dump5_beats", beats1, 31);
        check("dump5_count", q1.size(), 0);
        check("ra_never_zero", ra_zero, 0);

        // 6: abort on the 10th load word
        done_chk = 0;
        base = done0;
        start0(1'b1);
        for (int j = 0; j < 9; j++) begin
            b0.i_tvalid = 1'b1;
            b0.i_tdata  = 32'h2000 + j;
            wq.push_back({5'(j), 32'h2000 + j});
            @(posedge clk);
            #1;
        end
        b0.i_tvalid = 1'b1;
        b0.i_tdata  = 32'h2009;
        b0.i_abort  = 1'b1;
        @(posedge clk);
        #1;
        b0.i_abort  = 1'b0;
        b0.i_tvalid = 1'b0;
        @(negedge clk);
        check("abort_busy", b0.o_busy, 0);
        check("abort_tready", b0.o_tready, 0);
        repeat (4) @(posedge clk);
        #1;
        check("abort_no_done", done0, base);
        check("abort_writes", wq.size(), 0);
        for (int j = 0; j < 9; j++) check("abort_mem", mem0[j], 32'h2000 + j);
        check("abort_word10", mem0[9], 32'h1009);
        done_chk = 1;
        for (int j = 0; j < 32; j++)
            q0.push_back(j < 9 ? 32'h2000 + j : 32'h1000 + j);
        start0(1'b0);
        wait_done(1'b0, 1'b0, 400);
        check("restart_count", q0.size(), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
